pad_mask_load_ctrl: RTL and testbench

PAD_MASK_LOAD_CTRL -- requirements
Module: pad_mask_load_ctrl

---
 rtl/pad_mask_load_ctrl_pkg.sv | 27 ++
 rtl/pad_mask_load_ctrl_rr_pick4.sv | 25 ++
 rtl/pad_mask_load_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pad_mask_load_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mask_load_ctrl_pkg.sv
// Shared constants, default widths and FSM encoding for the pad mask load controller.
package pad_mask_load_ctrl_pkg;

    localparam int unsigned NUM_LAYERS     = 4;
    localparam int unsigned DEF_DEPTH      = 128;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W     = 9;
    localparam int unsigned DEF_TIMEOUT    = 1024;
    localparam int unsigned DEF_START_WAIT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StStart,
        StWaitBusy,
        StWaitDone
    } state_e;

    // One-hot layer select for the per-layer strobes.
    function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [1:0] layer);
        logic [NUM_LAYERS-1:0] oh;
        oh = '0;
        oh[layer] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pad_mask_load_ctrl_rr_pick4.sv
// Round-robin selector over four pending requests, searching upward from ptr with wrap.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] pick
);

    logic [1:0] idx;

    // First set request at or after ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/pad_mask_load_ctrl.sv
// Pad mask load controller: serialises mask RAM writes and per-layer serializer reloads,
// tracking which layers hold a current mask and flagging serializer timeouts.
module pad_mask_load_ctrl
    import pad_mask_load_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned START_WAIT = DEF_START_WAIT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_layer,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic [NUM_LAYERS-1:0] reload_req,
    input  logic                  err_clear,
    output logic [NUM_LAYERS-1:0] ram_wea,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    output logic [NUM_LAYERS-1:0] ser_start,
    input  logic [NUM_LAYERS-1:0] ser_busy,
    output logic [NUM_LAYERS-1:0] mask_valid,
    output logic [NUM_LAYERS-1:0] err_timeout,
    output logic                  addr_err,
    output logic                  ctrl_busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT > START_WAIT) ? TIMEOUT : START_WAIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e                  state_q, state_d;
    logic [1:0]              layer_q, layer_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       din_q, din_d;
    logic [NUM_LAYERS-1:0]   pending_q, pending_d;
    logic [NUM_LAYERS-1:0]   mask_q, mask_d;
    logic [NUM_LAYERS-1:0]   err_q, err_d;
    logic                    addr_err_q, addr_err_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    run_q;
    logic                    pick_found;
    logic [1:0]              pick;
    logic                    addr_ok;

    rr_pick4 u_rr_pick4 (
        .req   (pending_q),
        .ptr   (ptr_q),
        .found (pick_found),
        .pick  (pick)
    );

    assign addr_ok = ({1'b0, cfg_addr} < (ADDR_W + 1)'(DEPTH));

    // Strobes decode from the registered state so they are exactly one state long.
    assign cfg_ready   = run_q && (state_q == StIdle);
    assign ctrl_busy   = (state_q != StIdle);
    assign ram_wea     = (state_q == StWrite) ? layer_onehot(layer_q) : '0;
    assign ser_start   = (state_q == StStart) ? layer_onehot(layer_q) : '0;
    assign ram_addr    = addr_q;
    assign ram_din     = din_q;
    assign mask_valid  = mask_q;
    assign err_timeout = err_q;
    assign addr_err    = addr_err_q;

    // Next-state, bookkeeping and timeout counting.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        addr_d     = addr_q;
        din_d      = din_q;
        ptr_d      = ptr_q;
        addr_err_d = 1'b0;
        pending_d  = pending_q | reload_req;
        mask_d     = mask_q;
        err_d      = err_clear ? '0 : err_q;
        cnt_d      = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            StIdle: begin
                if (cfg_valid && cfg_ready) begin
                    if (addr_ok) begin
                        layer_d              = cfg_layer;
                        addr_d               = cfg_addr;
                        din_d                = cfg_data;
                        pending_d[cfg_layer] = 1'b1;
                        mask_d[cfg_layer]    = 1'b0;
                        state_d              = StWrite;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end else if (pick_found) begin
                    layer_d         = pick;
                    // A reload request landing now must survive the clear.
                    pending_d[pick] = reload_req[pick];
                    ptr_d           = pick + 2'd1;
                    state_d         = StStart;
                end
            end
            StWrite: state_d = StIdle;
            StStart: state_d = StWaitBusy;
            StWaitBusy: begin
                if (ser_busy[layer_q]) begin
                    state_d = StWaitDone;
                end else if (cnt_q >= CNT_W'(START_WAIT - 1)) begin
                    err_d[layer_q] = 1'b1;
                    state_d        = StIdle;
                end
            end
            StWaitDone: begin
                if (!ser_busy[layer_q]) begin
                    // A reload requested mid-flight means this result is already stale.
                    if (!pending_d[layer_q]) mask_d[layer_q] = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    err_d[layer_q]  = 1'b1;
                    mask_d[layer_q] = 1'b0;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            layer_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            err_q      <= '0;
            addr_err_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            addr_err_q <= addr_err_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            run_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pad_mask_load_ctrl.sv
// Scoreboard bench for pad_mask_load_ctrl: stimulus queues expected strobe events,
// a negedge monitor pops and compares them whenever the DUT pulses a strobe.
module tb_pad_mask_load_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_layer;
    logic [8:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [3:0] reload_req;
    logic       err_clear;
    logic [3:0] ram_wea;
    logic [8:0] ram_addr;
    logic [7:0] ram_din;
    logic [3:0] ser_start;
    logic [3:0] ser_busy;
    logic [3:0] mask_valid;
    logic [3:0] err_timeout;
    logic       addr_err;
    logic       ctrl_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] wea;
        logic [3:0] start;
        logic       aerr;
        logic       chk;
        logic [8:0] addr;
        logic [7:0] din;
    } ev_t;

    ev_t exp_q[$];

    // Serializer model controls
    int         busy_len = 8;
    logic [3:0] stuck    = '0;
    logic [3:0] noresp   = '0;
    logic [3:0] mdl_busy;
    int         mdl_cnt[4];

    always #5 clk = ~clk;

    pad_mask_load_ctrl u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_layer   (cfg_layer),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .reload_req  (reload_req),
        .err_clear   (err_clear),
        .ram_wea     (ram_wea),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ser_start   (ser_start),
        .ser_busy    (ser_busy),
        .mask_valid  (mask_valid),
        .err_timeout (err_timeout),
        .addr_err    (addr_err),
        .ctrl_busy   (ctrl_busy)
    );

    // Serializer: busy rises the cycle after start and stays high busy_len cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_busy <= '0;
            for (int i = 0; i < 4; i++) mdl_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ser_start[i] && !noresp[i]) begin
                    mdl_busy[i] <= 1'b1;
                    mdl_cnt[i]  <= busy_len - 1;
                end else if (mdl_busy[i]) begin
                    if (mdl_cnt[i] == 0) mdl_busy[i] <= 1'b0;
                    else mdl_cnt[i] <= mdl_cnt[i] - 1;
                end
            end
        end
    end

    assign ser_busy = mdl_busy | stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest expected event.
    always @(negedge clk) begin
        if (ram_wea != 4'd0 || ser_start != 4'd0 || addr_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got wea=%b start=%b aerr=%b expected none at %0t",
                         ram_wea, ser_start, addr_err, $time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_wea", 32'(ram_wea), 32'(e.wea));
                check("ev_start", 32'(ser_start), 32'(e.start));
                check("ev_addr_err", 32'(addr_err), 32'(e.aerr));
                if (e.chk) begin
                    check("ev_ram_addr", 32'(ram_addr), 32'(e.addr));
                    check("ev_ram_din", 32'(ram_din), 32'(e.din));
                end
            end
        end
    end

    task automatic push_start(input logic [3:0] v);
        exp_q.push_back('{wea: 4'd0, start: v, aerr: 1'b0, chk: 1'b0, addr: 9'd0, din: 8'd0});
    endtask

    task automatic push_wea(input logic [3:0] v, input logic [8:0] a, input logic [7:0] d);
        exp_q.push_back('{wea: v, start: 4'd0, aerr: 1'b0, chk: 1'b1, addr: a, din: d});
    endtask

    task automatic push_aerr();
        exp_q.push_back('{wea: 4'd0, start: 4'd0, aerr: 1'b1, chk: 1'b0, addr: 9'd0, din: 8'd0});
    endtask

    task automatic do_write(input logic [1:0] l, input logic [8:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_layer = l;
        cfg_addr  = a;
        cfg_data  = d;
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("write_accepted", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_reload(input logic [3:0] v);
        @(negedge clk);
        reload_req = v;
        @(negedge clk);
        reload_req = 4'd0;
    endtask

    task automatic wait_busy(input int i, input int budget);
        int n = 0;
        while (!ser_busy[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", 32'(ser_busy[i]), 32'd1);
    endtask

    task automatic wait_start(input int i);
        int n = 0;
        while (!ser_start[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(ser_start[i]), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || ctrl_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'({exp_q.size() == 0, !ctrl_busy}), 32'd3);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({cfg_ready, ram_wea, ser_start, mask_valid, err_timeout, addr_err,
                         ctrl_busy}), 32'd0);
        check(name, 32'({ram_addr, ram_din}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_layer  = 2'd0;
        cfg_addr   = 9'd0;
        cfg_data   = 8'd0;
        reload_req = 4'd0;
        err_clear  = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'({cfg_ready, ctrl_busy}), 32'b10);

        // Write layer 2 then its reload.
        push_wea(4'b0100, 9'd5, 8'hA5);
        push_start(4'b0100);
        do_write(2'd2, 9'd5, 8'hA5);
        check("mask_after_write", 32'(mask_valid), 32'd0);
        wait_idle(500);
        check("mask_after_reload2", 32'(mask_valid), 32'b0100);

        // Reload all layers from a fresh reset: order 0,1,2,3.
        do_reset();
        busy_len = 128;
        push_start(4'b0001);
        push_start(4'b0010);
        push_start(4'b0100);
        push_start(4'b1000);
        pulse_reload(4'b1111);
        wait_busy(3, 1000);
        check("mask_before_last", 32'(mask_valid), 32'b0111);
        wait_idle(1000);
        check("mask_all_valid", 32'(mask_valid), 32'b1111);

        // Address boundary: 200 and 128 dropped, 127 accepted.
        busy_len = 8;
        push_aerr();
        do_write(2'd0, 9'd200, 8'h11);
        repeat (10) @(negedge clk);
        check("mask_after_addr200", 32'(mask_valid), 32'b1111);
        check("busy_after_addr200", 32'(ctrl_busy), 32'd0);
        push_aerr();
        do_write(2'd1, 9'd128, 8'h22);
        repeat (10) @(negedge clk);
        check("mask_after_addr128", 32'(mask_valid), 32'b1111);
        push_wea(4'b1000, 9'd127, 8'h5A);
        push_start(4'b1000);
        do_write(2'd3, 9'd127, 8'h5A);
        check("mask_cleared_l3", 32'(mask_valid), 32'b0111);
        wait_idle(500);
        check("mask_after_l3", 32'(mask_valid), 32'b1111);
        check("ram_hold", 32'({ram_wea, ram_addr, ram_din}), 32'({4'd0, 9'd127, 8'h5A}));

        // Write held off during WAIT_DONE, then served before other pending reloads.
        busy_len = 40;
        push_start(4'b0001);
        pulse_reload(4'b0001);
        wait_busy(0, 100);
        @(negedge clk);
        check("ready_low_wait_done", 32'(cfg_ready), 32'd0);
        pulse_reload(4'b1000);
        push_wea(4'b0010, 9'd9, 8'h3C);
        push_start(4'b0010);
        push_start(4'b1000);
        do_write(2'd1, 9'd9, 8'h3C);
        wait_idle(1000);
        check("mask_after_held_write", 32'(mask_valid), 32'b1111);

        // Reload request during its own reload forces a second one.
        busy_len = 20;
        push_start(4'b0100);
        push_start(4'b0100);
        pulse_reload(4'b0100);
        wait_busy(2, 100);
        pulse_reload(4'b0100);
        wait_idle(500);
        check("mask_after_double", 32'(mask_valid), 32'b1111);

        // Serializer busy stuck: timeout in WAIT_DONE.
        stuck = 4'b0010;
        push_start(4'b0010);
        pulse_reload(4'b0010);
        wait_start(1);
        n = 0;
        while (!err_timeout[1] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout_cycles", 32'(n), 32'd1026);
        check("err_after_stuck", 32'(err_timeout), 32'b0010);
        check("mask_after_stuck", 32'(mask_valid), 32'b1101);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared", 32'(err_timeout), 32'd0);
        stuck = 4'b0000;

        // Serializer never responds: timeout in WAIT_BUSY.
        noresp = 4'b1000;
        push_start(4'b1000);
        pulse_reload(4'b1000);
        wait_start(3);
        n = 0;
        while (!err_timeout[3] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout_cycles", 32'(n), 32'd17);
        check("mask_after_noresp", 32'(mask_valid), 32'b1101);
        noresp = 4'b0000;
        wait_idle(50);

        // Reset during WAIT_DONE aborts with no further start.
        busy_len = 100;
        push_start(4'b0001);
        pulse_reload(4'b0001);
        wait_busy(0, 100);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_reload");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("after_abort", 32'({mask_valid, ctrl_busy, err_timeout}), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
